// File: rtl/zoom_instr_sequencer.sv
// zoom_instr_sequencer
//   Takes HPS PIO instructions into a small queue, one per rising edge of
//   instr_enable. It decodes the head entry and handles NOP, CLR and illegal
//   opcodes itself. Every other opcode goes to the zoom datapath with a
//   valid/ready handshake, and the block then waits for dp_done before it
//   takes the next entry.
// Ports:
//   clk_clk, reset_reset_n      clock, async active-low reset
//   instr_word, instr_enable    HPS instruction word / submit strobe level
//   dp_cmd_valid/ready          command handshake to the datapath
//   dp_opcode/param/addr/wdata  command fields, held while valid is high
//   dp_done, dp_rdata           completion pulse and LOAD read data
//   busy, fifo_full, fifo_count queue/FSM status
//   overflow, illegal           sticky error flags, cleared by CLR
//   rd_data                     data from the last completed LOAD
module zoom_instr_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 3
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic [31:0]      instr_word,
  input  logic             instr_enable,
  output logic             dp_cmd_valid,
  input  logic             dp_cmd_ready,
  output logic [3:0]       dp_opcode,
  output logic [2:0]       dp_param,
  output logic [16:0]      dp_addr,
  output logic [7:0]       dp_wdata,
  input  logic             dp_done,
  input  logic [7:0]       dp_rdata,
  output logic             busy,
  output logic             fifo_full,
  output logic [CNT_W-1:0] fifo_count,
  output logic             overflow,
  output logic             illegal,
  output logic [7:0]       rd_data
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_STORE = 4'd1;
  localparam logic [3:0] OP_LOAD  = 4'd2;
  localparam logic [3:0] OP_ZIN   = 4'd3;
  localparam logic [3:0] OP_ZOUT  = 4'd4;
  localparam logic [3:0] OP_CLR   = 4'd5;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t           r_state, w_state_d;
  logic             r_en_q;
  logic [31:0]      r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wptr, r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             r_valid, w_valid_d;
  logic [3:0]       r_op;
  logic [2:0]       r_param;
  logic [16:0]      r_addr;
  logic [7:0]       r_wdata;
  logic             r_ovf, r_ill;
  logic [7:0]       r_rd;

  logic             w_empty, w_full;
  logic             w_push_req, w_push, w_drop;
  logic             w_pop, w_load_cmd, w_set_ill, w_clr, w_cap;
  logic [31:0]      w_head;

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == CNT_W'(FIFO_DEPTH));
  // Rising-edge detect on the software strobe. en_q resets low, so an enable
  // that is already high when reset is released counts as one submission.
  assign w_push_req = instr_enable & ~r_en_q;
  // A full queue drops the submission even if a pop happens on the same edge.
  // The stored contents then stay exactly as they were.
  assign w_push     = w_push_req & ~w_full;
  assign w_drop     = w_push_req &  w_full;
  assign w_head     = r_mem[r_rptr];

  // Next-state and control
  always_comb begin
    w_state_d  = r_state;
    w_valid_d  = r_valid;
    w_pop      = 1'b0;
    w_load_cmd = 1'b0;
    w_set_ill  = 1'b0;
    w_clr      = 1'b0;
    w_cap      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop = 1'b1;
          case (w_head[31:28])
            OP_STORE, OP_LOAD, OP_ZIN, OP_ZOUT: begin
              w_load_cmd = 1'b1;
              w_valid_d  = 1'b1;
              w_state_d  = S_ISSUE;
            end
            OP_NOP:  ;
            OP_CLR:  w_clr = 1'b1;
            default: w_set_ill = 1'b1;
          endcase
        end
      end
      S_ISSUE: begin
        w_valid_d = 1'b1;
        if (dp_cmd_ready) begin
          w_valid_d = 1'b0;
          w_state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        w_valid_d = 1'b0;
        if (dp_done) begin
          w_cap     = (r_op == OP_LOAD);
          w_state_d = S_IDLE;
        end
      end
      default: begin
        w_valid_d = 1'b0;
        w_state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_state <= S_IDLE;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_valid <= w_valid_d;
    end
  end

  // Queue storage. It is never read while empty, so it needs no reset.
  always_ff @(posedge clk_clk) begin
    if (w_push) r_mem[r_wptr] <= instr_word;
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_en_q  <= 1'b0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      r_en_q <= instr_enable;
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Command register. It is loaded only for dispatched opcodes, so the
  // fields stay stable from ISSUE through WAIT.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_op    <= '0;
      r_param <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_load_cmd) begin
      r_op    <= w_head[31:28];
      r_param <= w_head[27:25];
      r_addr  <= w_head[24:8];
      r_wdata <= w_head[7:0];
    end
  end

  // Sticky flags. When a set event lands on the same edge as a CLR pop,
  // the set takes priority.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_ovf <= 1'b0;
      r_ill <= 1'b0;
      r_rd  <= '0;
    end else begin
      if (w_drop)      r_ovf <= 1'b1;
      else if (w_clr)  r_ovf <= 1'b0;
      if (w_set_ill)   r_ill <= 1'b1;
      else if (w_clr)  r_ill <= 1'b0;
      if (w_cap)       r_rd  <= dp_rdata;
    end
  end

  assign dp_cmd_valid = r_valid;
  assign dp_opcode    = r_op;
  assign dp_param     = r_param;
  assign dp_addr      = r_addr;
  assign dp_wdata     = r_wdata;
  assign busy         = (r_state != S_IDLE) | ~w_empty;
  assign fifo_full    = w_full;
  assign fifo_count   = r_count;
  assign overflow     = r_ovf;
  assign illegal      = r_ill;
  assign rd_data      = r_rd;

endmodule

// File: tb/tb_zoom_instr_sequencer.sv
// Bench for zoom_instr_sequencer. Directed scenarios are followed by
// randomized bursts served by an in-bench datapath responder. Expected
// commands come from a queue of submitted words in program order.
module tb_zoom_instr_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr_word = '0;
  logic        instr_enable = 1'b0;
  logic        dp_cmd_valid, dp_cmd_ready = 1'b0;
  logic [3:0]  dp_opcode;
  logic [2:0]  dp_param;
  logic [16:0] dp_addr;
  logic [7:0]  dp_wdata;
  logic        dp_done = 1'b0;
  logic [7:0]  dp_rdata = '0;
  logic        busy, fifo_full, overflow, illegal;
  logic [2:0]  fifo_count;
  logic [7:0]  rd_data;

  zoom_instr_sequencer #(.FIFO_DEPTH(4), .CNT_W(3)) dut (
    .clk_clk(clk), .reset_reset_n(rst_n),
    .instr_word(instr_word), .instr_enable(instr_enable),
    .dp_cmd_valid(dp_cmd_valid), .dp_cmd_ready(dp_cmd_ready),
    .dp_opcode(dp_opcode), .dp_param(dp_param), .dp_addr(dp_addr),
    .dp_wdata(dp_wdata), .dp_done(dp_done), .dp_rdata(dp_rdata),
    .busy(busy), .fifo_full(fifo_full), .fifo_count(fifo_count),
    .overflow(overflow), .illegal(illegal), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [31:0] exp_q[$];
  logic [7:0]  exp_rd;
  logic        exp_ill;
  logic        auto_dp = 1'b0;
  int          ph = 0;
  int          dcnt = 0;
  logic [3:0]  last_op = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input int op, input int prm, input int addr, input int dat);
    return {4'(op), 3'(prm), 17'(addr), 8'(dat)};
  endfunction

  // Datapath responder. It runs once per falling edge and drives the values
  // seen at the next rising edge.
  task automatic dp_step();
    logic [31:0] w;
    dp_done = 1'b0;
    if (ph == 0) begin
      dp_cmd_ready = ($urandom_range(0, 2) != 0);
      if (dp_cmd_valid && dp_cmd_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_cmd", 32'd1, 32'd0);
        end else begin
          w = exp_q.pop_front();
          chk("hs_cmd", {dp_opcode, dp_param, dp_addr, dp_wdata}, w);
          last_op = w[31:28];
        end
        ph   = 1;
        dcnt = $urandom_range(0, 3);
      end else if ($urandom_range(0, 9) == 0) begin
        dp_done  = 1'b1;              // stray pulse outside WAIT
        dp_rdata = 8'($urandom);
      end
    end else begin
      dp_cmd_ready = ($urandom_range(0, 1) != 0);
      if (dcnt == 0) begin
        dp_done  = 1'b1;
        dp_rdata = 8'($urandom);
        if (last_op == 4'd2) exp_rd = dp_rdata;
        ph = 0;
      end else begin
        dcnt--;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (auto_dp) dp_step();
  endtask

  task automatic submit(input logic [31:0] w);
    instr_word   = w;
    instr_enable = 1'b1;
    tick();
    instr_enable = 1'b0;
    tick();
  endtask

  // Waits for the next command, checks its data, then completes it.
  task automatic serve(input logic [7:0] wd, input logic [7:0] rdat);
    int n = 0;
    while (!dp_cmd_valid && n < 50) begin tick(); n++; end
    chk("serve_valid", dp_cmd_valid, 1);
    chk("serve_wdata", dp_wdata, wd);
    dp_cmd_ready = 1'b1;
    tick();
    dp_cmd_ready = 1'b0;
    dp_rdata = rdat;
    dp_done  = 1'b1;
    tick();
    dp_done  = 1'b0;
  endtask

  initial begin
    exp_rd  = '0;
    exp_ill = 1'b0;

    // Reset state
    repeat (3) tick();
    chk("rst_valid", dp_cmd_valid, 0);
    chk("rst_fields", {dp_opcode, dp_param, dp_addr, dp_wdata}, 0);
    chk("rst_status", {busy, fifo_full, fifo_count, overflow, illegal}, 0);
    chk("rst_rd", rd_data, 0);
    rst_n = 1'b1;
    tick();

    // STORE: count after E0, valid after E1, fields held while ready is low
    instr_word   = mk(1, 0, 'h01234, 'h5A);
    instr_enable = 1'b1;
    tick();
    chk("store_count1", fifo_count, 1);
    chk("store_busy", busy, 1);
    instr_enable = 1'b0;
    tick();
    chk("store_valid", dp_cmd_valid, 1);
    chk("store_fields", {dp_opcode, dp_addr, dp_wdata}, {4'd1, 17'h01234, 8'h5A});
    repeat (3) tick();
    chk("store_stable", {dp_cmd_valid, dp_opcode, dp_param, dp_addr, dp_wdata},
        {1'b1, mk(1, 0, 'h01234, 'h5A)});
    dp_cmd_ready = 1'b1;
    tick();
    dp_cmd_ready = 1'b0;
    chk("store_valid_drop", dp_cmd_valid, 0);
    chk("store_wait_busy", busy, 1);
    dp_done = 1'b1;
    tick();
    dp_done = 1'b0;
    chk("store_done_busy", busy, 0);

    // LOAD read-back persists through a later STORE
    submit(mk(2, 0, 7, 0));
    chk("load_fields", {dp_cmd_valid, dp_opcode, dp_addr}, {1'b1, 4'd2, 17'd7});
    dp_cmd_ready = 1'b1; tick(); dp_cmd_ready = 1'b0;
    dp_rdata = 8'hC3; dp_done = 1'b1; tick(); dp_done = 1'b0;
    chk("load_rd", rd_data, 8'hC3);
    submit(mk(1, 2, 100, 'h11));
    serve(8'h11, 8'h55);
    chk("load_rd_persist", rd_data, 8'hC3);

    // Overflow: ready low, six submissions
    for (int i = 0; i < 6; i++) begin
      submit(mk(1, 1, i, i));
      if (i == 4) begin
        chk("ovf_count4", fifo_count, 4);
        chk("ovf_full", fifo_full, 1);
        chk("ovf_not_yet", overflow, 0);
      end
    end
    chk("ovf_set", overflow, 1);
    chk("ovf_count_kept", fifo_count, 4);
    for (int i = 0; i < 5; i++) serve(8'(i), 8'h00);
    repeat (5) tick();
    chk("ovf_no_extra", {dp_cmd_valid, busy}, 0);

    // Illegal then CLR
    submit(mk(9, 0, 0, 0));
    chk("ill_set", illegal, 1);
    chk("ill_no_valid", dp_cmd_valid, 0);
    chk("ill_idle", busy, 0);
    submit(mk(5, 0, 0, 0));
    chk("clr_flags", {overflow, illegal}, 0);

    // Enable held high: one push only
    instr_word   = mk(1, 0, 3, 'h77);
    instr_enable = 1'b1;
    repeat (20) tick();
    instr_enable = 1'b0;
    chk("hold_count", fifo_count, 0);
    chk("hold_valid", dp_cmd_valid, 1);
    serve(8'h77, 8'h00);
    repeat (3) tick();
    chk("hold_single", {dp_cmd_valid, busy}, 0);

    // Push and pop on the same edge at count 2
    submit(mk(1, 0, 0, 'hA0));
    submit(mk(1, 0, 0, 'hB0));
    submit(mk(1, 0, 0, 'hC0));
    chk("pp_count2", fifo_count, 2);
    dp_cmd_ready = 1'b1; tick(); dp_cmd_ready = 1'b0;
    dp_done = 1'b1; tick(); dp_done = 1'b0;
    instr_word   = mk(1, 0, 0, 'hD0);
    instr_enable = 1'b1;
    tick();
    instr_enable = 1'b0;
    chk("pp_count_same", fifo_count, 2);
    chk("pp_valid", {dp_cmd_valid, dp_wdata}, {1'b1, 8'hB0});
    serve(8'hB0, 0);
    serve(8'hC0, 0);
    serve(8'hD0, 0);

    // Async reset in WAIT with three entries queued
    for (int i = 0; i < 4; i++) submit(mk(1, 0, 0, 'h10 + i));
    dp_cmd_ready = 1'b1; tick(); dp_cmd_ready = 1'b0;
    chk("ar_pre_count", fifo_count, 3);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_now", {dp_cmd_valid, fifo_count, busy}, 0);
    tick();
    rst_n = 1'b1;
    dp_rdata = 8'hEE; dp_done = 1'b1;
    tick();
    dp_done = 1'b0;
    tick();
    chk("ar_stray_done", {dp_cmd_valid, busy, fifo_count, rd_data}, 0);

    // Randomized bursts. A burst of at most four entries, started with the
    // queue empty, cannot overflow.
    exp_rd  = '0;
    exp_ill = 1'b0;
    ph      = 0;
    auto_dp = 1'b1;
    for (int b = 0; b < 40; b++) begin
      int nb;
      nb = $urandom_range(1, 4);
      for (int k = 0; k < nb; k++) begin
        int r, op;
        r = $urandom_range(0, 9);
        if (r < 6)       op = 1 + (r % 4);
        else if (r == 6) op = 0;
        else if (r == 7) op = 5;
        else             op = $urandom_range(6, 15);
        if (op >= 1 && op <= 4) exp_q.push_back(mk(op, $urandom_range(0, 7),
                                     $urandom_range(0, 76799), $urandom_range(0, 255)));
        else                    exp_q.push_back(mk(op, 0, 0, 0));
        instr_word = exp_q[exp_q.size()-1];
        if (op < 1 || op > 4) void'(exp_q.pop_back());
        if (op == 5) exp_ill = 1'b0;
        if (op >= 6) exp_ill = 1'b1;
        instr_enable = 1'b1;
        tick();
        instr_enable = 1'b0;
        tick();
      end
      begin
        int n = 0;
        while (busy && n < 300) begin tick(); n++; end
      end
      chk("rnd_drain", busy, 0);
      chk("rnd_illegal", illegal, exp_ill);
      chk("rnd_rd", rd_data, exp_rd);
      chk("rnd_overflow", overflow, 0);
      chk("rnd_q_empty", exp_q.size(), 0);
    end
    auto_dp = 1'b0;
    dp_cmd_ready = 1'b0;
    dp_done = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
